// File: rtl/ctrl_hub_pkg.sv
// Shared constants, types and frame validation for the multi-channel controller receiver.
package ctrl_hub_pkg;

    localparam logic [7:0] CTRL_HEADER     = 8'hA5;
    localparam int         CTRL_FRAME_BITS = 40;
    localparam logic [7:0] JOY_NEUTRAL     = 8'h80;

    typedef struct packed {
        logic [7:0] buttons;
        logic [7:0] joy_x;
        logic [7:0] joy_y;
    } ctrl_state_t;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RECV,
        CH_CHECK
    } ctrl_ch_state_t;

    localparam ctrl_state_t CTRL_STATE_NEUTRAL = '{buttons: 8'h00, joy_x: JOY_NEUTRAL, joy_y: JOY_NEUTRAL};

    function automatic logic frame_valid(input logic [CTRL_FRAME_BITS-1:0] f);
        return (f[39:32] == CTRL_HEADER) && (f[7:0] == (f[31:24] ^ f[23:16] ^ f[15:8]));
    endfunction

endpackage

// File: rtl/ctrl_rx_channel.sv
// One controller link: synchroniser, edge detect, framing FSM, check, timeout and error stats.
// Error counter is built only when CTRL_RX_HUB_STATS_EN is defined.
module ctrl_rx_channel
    import ctrl_hub_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       data_raw,
    input  logic       clk_raw,
    output logic [7:0] buttons,
    output logic [7:0] joy_x,
    output logic [7:0] joy_y,
    output logic       connected,
    output logic       frame_strobe,
    output logic [7:0] err_count
);

    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0]     data_sync, clk_sync;
    logic                       clk_prev;
    logic                       link_edge, link_bit;
    ctrl_ch_state_t             state, state_next;
    logic [CTRL_FRAME_BITS-1:0] shreg;
    logic [5:0]                 bit_cnt;
    logic [GAP_W-1:0]           gap_cnt;
    logic                       gap_expire;
    logic                       check_pass;
    logic [TOUT_W-1:0]          tout_cnt;
    ctrl_state_t                latched;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_sync <= '0;
            clk_sync  <= '0;
            clk_prev  <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value, forming a real chain.
            data_sync <= {data_sync[SYNC_STAGES-2:0], data_raw};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], clk_raw};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign link_edge  = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign link_bit   = data_sync[SYNC_STAGES-1];
    assign gap_expire = (state == CH_RECV) && !link_edge && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign check_pass = (state == CH_CHECK) && frame_valid(shreg);

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            CH_IDLE:  if (link_edge) state_next = CH_RECV;
            CH_RECV: begin
                if (link_edge && bit_cnt == 6'(CTRL_FRAME_BITS - 1)) state_next = CH_CHECK;
                else if (gap_expire)                                 state_next = CH_IDLE;
            end
            CH_CHECK: state_next = CH_IDLE;
            default:  state_next = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= CH_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_next;
            if (link_edge && state != CH_CHECK) begin
                bit_cnt <= (state == CH_IDLE) ? 6'd1 : bit_cnt + 6'd1;
                gap_cnt <= '0;
            end else if (state == CH_RECV) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // NOTE: the shift register has no reset; it is only read in CHECK, after 40 fresh bits have filled it.
    always_ff @(posedge clk_in) begin
        if (link_edge && state != CH_CHECK) shreg <= {shreg[CTRL_FRAME_BITS-2:0], link_bit};
    end

    // A valid frame takes priority over timeout expiry in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            latched      <= CTRL_STATE_NEUTRAL;
            connected    <= 1'b0;
            frame_strobe <= 1'b0;
            tout_cnt     <= '0;
        end else begin
            frame_strobe <= check_pass;
            if (check_pass) begin
                latched   <= shreg[31:8];
                connected <= 1'b1;
                tout_cnt  <= '0;
            end else begin
                if (tout_cnt != TOUT_W'(TIMEOUT_CYCLES)) tout_cnt <= tout_cnt + TOUT_W'(1);
                if (tout_cnt >= TOUT_W'(TIMEOUT_CYCLES - 1)) begin
                    latched   <= CTRL_STATE_NEUTRAL;
                    connected <= 1'b0;
                end
            end
        end
    end

    assign buttons = latched.buttons;
    assign joy_x   = latched.joy_x;
    assign joy_y   = latched.joy_y;

`ifdef CTRL_RX_HUB_STATS_EN
    logic err_event;
    assign err_event = gap_expire || ((state == CH_CHECK) && !frame_valid(shreg));

    always_ff @(posedge clk_in) begin
        if (rst_in)                             err_count <= 8'h00;
        else if (err_event && err_count != 8'hFF) err_count <= err_count + 8'h01;
    end
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: rtl/ctrl_rx_hub.sv
// Multi-channel controller receiver: one independent ctrl_rx_channel per link, outputs packed 8 bits per channel.
// Optional per-channel error counters via CTRL_RX_HUB_STATS_EN.
module ctrl_rx_hub #(
    parameter int NUM_CHANNELS   = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_CHANNELS-1:0]   chip_data_raw,
    input  logic [NUM_CHANNELS-1:0]   chip_clk_raw,
    output logic [NUM_CHANNELS*8-1:0] buttons_out,
    output logic [NUM_CHANNELS*8-1:0] joy_x_out,
    output logic [NUM_CHANNELS*8-1:0] joy_y_out,
    output logic [NUM_CHANNELS-1:0]   connected_out,
    output logic [NUM_CHANNELS-1:0]   frame_strobe_out,
    output logic [NUM_CHANNELS*8-1:0] err_count_out
);

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        ctrl_rx_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .GAP_CYCLES    (GAP_CYCLES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_ch (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .data_raw    (chip_data_raw[i]),
            .clk_raw     (chip_clk_raw[i]),
            .buttons     (buttons_out[8*i +: 8]),
            .joy_x       (joy_x_out[8*i +: 8]),
            .joy_y       (joy_y_out[8*i +: 8]),
            .connected   (connected_out[i]),
            .frame_strobe(frame_strobe_out[i]),
            .err_count   (err_count_out[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_ctrl_rx_hub.sv
// Self-checking bench for ctrl_rx_hub: directed and randomized frames on two links against a frame-level model.
module tb_ctrl_rx_hub;

    localparam int NCH       = 2;
    localparam int SYNC      = 2;
    localparam int GAP       = 1000;
    localparam int TOUT      = 5000;
    localparam int HALF_LINK = 4;
`ifdef CTRL_RX_HUB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic [NCH-1:0]       chip_data_raw, chip_clk_raw;
    logic [NCH*8-1:0]     buttons_out, joy_x_out, joy_y_out, err_count_out;
    logic [NCH-1:0]       connected_out, frame_strobe_out;

    ctrl_rx_hub #(
        .NUM_CHANNELS  (NCH),
        .SYNC_STAGES   (SYNC),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .chip_data_raw   (chip_data_raw),
        .chip_clk_raw    (chip_clk_raw),
        .buttons_out     (buttons_out),
        .joy_x_out       (joy_x_out),
        .joy_y_out       (joy_y_out),
        .connected_out   (connected_out),
        .frame_strobe_out(frame_strobe_out),
        .err_count_out   (err_count_out)
    );

    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int          strobes_seen = 0;
    int          strobes_exp  = 0;

    always @(posedge clk_in) cyc++;
    always @(negedge clk_in) strobes_seen += $countones(frame_strobe_out);

    // Frame-level model: what each channel should be presenting.
    logic [7:0]  m_btn [NCH];
    logic [7:0]  m_jx  [NCH];
    logic [7:0]  m_jy  [NCH];
    logic [7:0]  m_err [NCH];
    logic        m_conn[NCH];
    int unsigned m_acc [NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] make_frame(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
        return {8'hA5, b, x, y, b ^ x ^ y};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_btn[c] = 8'h00; m_jx[c] = 8'h80; m_jy[c] = 8'h80;
            m_err[c] = 8'h00; m_conn[c] = 1'b0; m_acc[c] = 0;
        end
    endtask

    task automatic model_error(input int c);
        if (STATS && m_err[c] != 8'hFF) m_err[c] = m_err[c] + 8'h01;
    endtask

    task automatic model_frame(input int c, input logic [39:0] f, output logic ok);
        logic [7:0] hdr, b, x, y, cs;
        {hdr, b, x, y, cs} = f;
        ok = (hdr == 8'hA5) && (cs == (b ^ x ^ y));
        if (ok) begin
            m_btn[c] = b; m_jx[c] = x; m_jy[c] = y;
            m_conn[c] = 1'b1; m_acc[c] = cyc;
        end else begin
            model_error(c);
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NCH; c++) begin
            if (m_conn[c] && (cyc - m_acc[c] > TOUT)) begin
                m_btn[c] = 8'h00; m_jx[c] = 8'h80; m_jy[c] = 8'h80; m_conn[c] = 1'b0;
            end
            check($sformatf("%s_ch%0d_btn", tag, c),  buttons_out[8*c +: 8],   m_btn[c]);
            check($sformatf("%s_ch%0d_jx", tag, c),   joy_x_out[8*c +: 8],     m_jx[c]);
            check($sformatf("%s_ch%0d_jy", tag, c),   joy_y_out[8*c +: 8],     m_jy[c]);
            check($sformatf("%s_ch%0d_conn", tag, c), connected_out[c],        m_conn[c]);
            check($sformatf("%s_ch%0d_err", tag, c),  err_count_out[8*c +: 8], m_err[c]);
        end
    endtask

    // Each bit: clock low with data for HALF_LINK cycles, then rising edge; the last bit ends on its rise.
    task automatic send(input logic [39:0] f0, input logic [39:0] f1, input logic [NCH-1:0] en, input int nbits);
        logic [39:0] f[NCH];
        f[0] = f0; f[1] = f1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < NCH; c++) begin
                if (en[c]) begin
                    chip_clk_raw[c]  = 1'b0;
                    chip_data_raw[c] = f[c][39-b];
                end
            end
            repeat (HALF_LINK) @(posedge clk_in);
            #1;
            for (int c = 0; c < NCH; c++) if (en[c]) chip_clk_raw[c] = 1'b1;
            if (b != nbits - 1) begin
                repeat (HALF_LINK) @(posedge clk_in);
                #1;
            end
        end
    endtask

    // Strobe must appear exactly SYNC+2 cycles after the last rising edge, for one cycle.
    task automatic finish_frame(input logic [39:0] f0, input logic [39:0] f1, input logic [NCH-1:0] en,
                                input string tag);
        logic [39:0]    f[NCH];
        logic [NCH-1:0] exp_strobe;
        logic           ok;
        f[0] = f0; f[1] = f1;
        exp_strobe = '0;
        for (int k = 1; k <= SYNC + 1; k++) begin
            @(posedge clk_in); #1;
            check($sformatf("%s_early_strobe%0d", tag, k), frame_strobe_out, '0);
        end
        @(posedge clk_in); #1;
        for (int c = 0; c < NCH; c++) begin
            if (en[c]) begin
                model_frame(c, f[c], ok);
                exp_strobe[c] = ok;
            end
        end
        strobes_exp += $countones(exp_strobe);
        check({tag, "_strobe"}, frame_strobe_out, exp_strobe);
        check_all(tag);
        @(posedge clk_in); #1;
        check({tag, "_strobe_off"}, frame_strobe_out, '0);
    endtask

    initial begin
        logic [39:0]    f0, f1;
        logic [NCH-1:0] en;

        rst_in = 1'b1;
        chip_data_raw = '0;
        chip_clk_raw  = '0;
        model_reset();
        repeat (4) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        check_all("reset");
        check("reset_strobe", frame_strobe_out, '0);

        f0 = 40'hA5_3C_10_F0_DC;
        send(f0, 40'h0, 2'b01, 40);
        finish_frame(f0, 40'h0, 2'b01, "first");

        f0 = 40'hA5_3C_10_F0_00;
        send(f0, 40'h0, 2'b01, 40);
        finish_frame(f0, 40'h0, 2'b01, "badsum");

        f0 = {8'h5A, 32'($urandom())};
        send(f0, 40'h0, 2'b01, 20);
        repeat (GAP + 20) @(posedge clk_in);
        #1;
        model_error(0);
        check_all("gap");

        f0 = 40'hA5_01_80_80_01;
        send(f0, 40'h0, 2'b01, 40);
        finish_frame(f0, 40'h0, 2'b01, "after_gap");

        repeat (TOUT - 10) @(posedge clk_in);
        #1;
        check("pre_timeout_conn", connected_out[0], 1'b1);
        repeat (20) @(posedge clk_in);
        #1;
        check("timeout_conn", connected_out[0], 1'b0);
        check_all("timeout");

        f0 = make_frame(8'($urandom()), 8'($urandom()), 8'($urandom()));
        f1 = make_frame(8'($urandom()), 8'($urandom()), 8'($urandom()));
        send(f0, f1, 2'b11, 40);
        finish_frame(f0, f1, 2'b11, "both");

        for (int i = 0; i < 8; i++) begin
            en = NCH'($urandom_range(1, 3));
            f0 = make_frame(8'($urandom()), 8'($urandom()), 8'($urandom()));
            f1 = make_frame(8'($urandom()), 8'($urandom()), 8'($urandom()));
            if ($urandom_range(0, 3) == 0) f0 = f0 ^ (40'd1 << $urandom_range(0, 39));
            if ($urandom_range(0, 3) == 0) f1 = f1 ^ (40'd1 << $urandom_range(0, 39));
            send(f0, f1, en, 40);
            finish_frame(f0, f1, en, $sformatf("rand%0d", i));
        end

        f0 = make_frame(8'($urandom()), 8'($urandom()), 8'($urandom()));
        f1 = make_frame(8'($urandom()), 8'($urandom()), 8'($urandom()));
        send(f0, f1, 2'b11, 25);
        rst_in = 1'b1;
        chip_clk_raw = '0;
        repeat (SYNC + 2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
        repeat (SYNC + 4) @(posedge clk_in);
        #1;
        check_all("rst_mid");
        check("rst_mid_strobe", frame_strobe_out, '0);

        send(f0, f1, 2'b11, 40);
        finish_frame(f0, f1, 2'b11, "post_rst");

        repeat (10) @(posedge clk_in);
        #1;
        check("strobe_total", strobes_seen, strobes_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
